// File: rtl/mac_accum_lp.sv
// mac_accum_lp: saturating dot-product accumulator for MULT_LP products with valid/ready result and downstream clock-enable.
module mac_accum_lp #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN_IN,
  input  logic [15:0]      PROD,
  input  logic             PROD_VALID,
  output logic             PROD_READY,
  output logic [ACC_W-1:0] RES,
  output logic             RES_SAT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             BUSY,
  output logic             CLK_EN
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   sum;
  assign sum        = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, PROD};
  assign PROD_READY = state_q == ACCUM;
  assign RES_VALID  = state_q == DONE;
  assign BUSY       = state_q != IDLE;
  assign CLK_EN     = BUSY | START;
  assign RES        = acc_q;
  assign RES_SAT    = sat_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (START) begin
        len_d   = LEN_IN;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = LEN_IN == '0 ? DONE : ACCUM;
      end
      ACCUM: if (PROD_VALID) begin
        // overflow pins acc at all ones, so a saturated vector stays saturated
        acc_d   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat_d   = sat_q | sum[ACC_W];
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == len_q - 1'b1 ? DONE : ACCUM;
      end
      DONE: state_d = RES_READY ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_mac_accum_lp.sv
// tb_mac_accum_lp: directed stimulus for mac_accum_lp, checked every cycle against a plain-arithmetic model plus literal expectations.
module tb_mac_accum_lp;
  localparam int ACC_W = 24;
  localparam int CNT_W = 10;
  localparam longint MAX = (64'd1 << ACC_W) - 1;
  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic [CNT_W-1:0] LEN_IN = '0;
  logic [15:0]      PROD = '0;
  logic             PROD_VALID = 1'b0;
  logic             PROD_READY;
  logic [ACC_W-1:0] RES;
  logic             RES_SAT;
  logic             RES_VALID;
  logic             RES_READY = 1'b0;
  logic             BUSY;
  logic             CLK_EN;
  int errors = 0;
  int checks = 0;
  mac_accum_lp #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .LEN_IN(LEN_IN),
    .PROD(PROD), .PROD_VALID(PROD_VALID), .PROD_READY(PROD_READY),
    .RES(RES), .RES_SAT(RES_SAT), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .BUSY(BUSY), .CLK_EN(CLK_EN)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // model: mode 0 idle, 1 collecting products, 2 holding a result
  int     m_mode = 0;
  longint m_acc = 0;
  int     m_left = 0;
  bit     m_sat = 0;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_mode = 0; m_acc = 0; m_left = 0; m_sat = 0;
    end else if (m_mode == 0) begin
      if (START) begin
        m_acc = 0; m_sat = 0; m_left = int'(LEN_IN);
        m_mode = m_left == 0 ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      if (PROD_VALID) begin
        m_acc = m_acc + longint'(PROD);
        if (m_acc > MAX) begin m_acc = MAX; m_sat = 1; end
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
    end else if (RES_READY) m_mode = 0;
  end
  always @(negedge CLK) begin
    chk("prod_ready", PROD_READY, m_mode == 1);
    chk("res_valid", RES_VALID, m_mode == 2);
    chk("busy", BUSY, m_mode != 0);
    chk("clk_en", CLK_EN, m_mode != 0 || START);
    chk("res", RES, m_acc);
    chk("res_sat", RES_SAT, m_sat);
  end
  task automatic tick; @(posedge CLK); #1; endtask
  task automatic start(input int len);
    START = 1'b1; LEN_IN = CNT_W'(len); tick; START = 1'b0;
  endtask
  task automatic send(input int p);
    PROD = 16'(p); PROD_VALID = 1'b1; tick; PROD_VALID = 1'b0;
  endtask
  task automatic take; RES_READY = 1'b1; tick; RES_READY = 1'b0; endtask
  task automatic wait_valid(input int budget);
    int n = 0;
    while (!RES_VALID && n < budget) begin tick; n++; end
    chk("wait_valid_timeout", RES_VALID, 1'b1);
  endtask
  initial begin
    tick; tick;
    chk("rst_busy", BUSY, 0); chk("rst_valid", RES_VALID, 0); chk("rst_res", RES, 0);
    chk("rst_ready", PROD_READY, 0);
    RST_N = 1'b1; tick;
    // 1: basic 4-product vector
    start(4);
    chk("t1_busy", BUSY, 1);
    send(100); send(200); send(300);
    chk("t1_not_yet", RES_VALID, 0);
    send(400);
    chk("t1_valid", RES_VALID, 1); chk("t1_res", RES, 1000); chk("t1_sat", RES_SAT, 0);
    take;
    chk("t1_drop", RES_VALID, 0);
    // 2: zero-length vector
    start(0);
    chk("t2_valid", RES_VALID, 1); chk("t2_res", RES, 0); chk("t2_ready", PROD_READY, 0);
    take;
    // 3: saturation
    start(300);
    for (int i = 0; i < 256; i++) send(65535);
    chk("t3_256", RES, 16776960); chk("t3_256_sat", RES_SAT, 0);
    send(65535);
    chk("t3_257", RES, 24'hFFFFFF); chk("t3_257_sat", RES_SAT, 1);
    for (int i = 0; i < 43; i++) send(65535);
    wait_valid(4);
    chk("t3_res", RES, 24'hFFFFFF); chk("t3_sat", RES_SAT, 1);
    take;
    // 4: valid gaps and result back-pressure
    start(3);
    send(7); tick; tick; send(8); send(9);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold", RES, 24); chk("t4_valid", RES_VALID, 1); chk("t4_ready", PROD_READY, 0);
      tick;
    end
    take;
    chk("t4_drop", RES_VALID, 0); chk("t4_retain", RES, 24);
    // 5: reset mid-vector
    start(4);
    send(1); send(2);
    #2 RST_N = 1'b0; #1;
    chk("t5_res", RES, 0); chk("t5_busy", BUSY, 0); chk("t5_valid", RES_VALID, 0);
    chk("t5_ready", PROD_READY, 0); chk("t5_clken", CLK_EN, 0);
    tick; tick; RST_N = 1'b1; tick;
    chk("t5_idle", BUSY, 0);
    start(1); send(7);
    chk("t5_valid2", RES_VALID, 1); chk("t5_res2", RES, 7); chk("t5_sat2", RES_SAT, 0);
    take;
    // 6: START ignored outside IDLE
    START = 1'b1; LEN_IN = CNT_W'(5); #1;
    chk("t6_clken_start", CLK_EN, 1);
    tick; START = 1'b0;
    send(1);
    START = 1'b1; send(2); START = 1'b0;
    send(3); send(4); send(5);
    chk("t6_valid", RES_VALID, 1); chk("t6_res", RES, 15); chk("t6_clken_done", CLK_EN, 1);
    START = 1'b1; take; START = 1'b0; #1;
    chk("t6_idle", BUSY, 0); chk("t6_drop", RES_VALID, 0); chk("t6_clken_idle", CLK_EN, 0);
    tick;
    chk("t6_still_idle", BUSY, 0);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
